// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity encodings and Tx state encoding
package uart_pkg;

  // Parity selector encodings, shared by the transmit and receive sides
  localparam logic [1:0] NOPARITY00 = 2'b00;
  localparam logic [1:0] ODD        = 2'b01;
  localparam logic [1:0] EVEN       = 2'b10;
  localparam logic [1:0] NOPARITY11 = 2'b11;

  // Transmit frame builder states
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_SYNC   = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4,
    TX_STOP   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/uart_parity_gen.sv
// rtl/uart_parity_gen.sv - combinational parity bit and enable from a data word
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            parity_type,
  output logic                  parity_bit,
  output logic                  parity_en
);

  // Odd makes the total count of ones (data + parity) odd, even makes it even
  always_comb begin
    parity_en  = (parity_type == ODD) || (parity_type == EVEN);
    parity_bit = 1'b0;
    if (parity_type == ODD) begin
      parity_bit = ~^data;
    end else if (parity_type == EVEN) begin
      parity_bit = ^data;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit frame builder: start, data LSB first, parity, stop
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            parity_type,
  input  logic                  stop_bits,
  output logic                  data_tx,
  output logic                  ready,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  stop_bits_q, stop_bits_d;
  logic                  parity_en_q, parity_en_d;
  logic                  parity_bit_q, parity_bit_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  logic                  gen_parity_bit;
  logic                  gen_parity_en;

  // Parity is taken from the word as it is latched, so the shift register
  // may be consumed freely during the frame.
  uart_parity_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_gen (
    .data        (data_in),
    .parity_type (parity_type),
    .parity_bit  (gen_parity_bit),
    .parity_en   (gen_parity_en)
  );

  // Next-state, next line value and frame bookkeeping
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    stop_bits_d  = stop_bits_q;
    parity_en_d  = parity_en_q;
    parity_bit_d = parity_bit_q;
    tx_d         = tx_q;
    done_d       = 1'b0;

    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (send) begin
          shift_d      = data_in;
          stop_bits_d  = stop_bits;
          parity_en_d  = gen_parity_en;
          parity_bit_d = gen_parity_bit;
          bit_cnt_d    = '0;
          stop_cnt_d   = 1'b0;
          state_d      = TX_SYNC;
        end
      end
      TX_SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            if (parity_en_q) begin
              tx_d    = parity_bit_q;
              state_d = TX_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = TX_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      TX_PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (stop_cnt_q == stop_bits_q) begin
            done_d  = 1'b1;
            state_d = TX_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset forces an idle-high line with no done
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= TX_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      stop_bits_q  <= 1'b0;
      parity_en_q  <= 1'b0;
      parity_bit_q <= 1'b0;
      tx_q         <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      stop_bits_q  <= stop_bits_d;
      parity_en_q  <= parity_en_d;
      parity_bit_q <= parity_bit_d;
      tx_q         <= tx_d;
      done_q       <= done_d;
    end
  end

  assign data_tx = tx_q;
  assign done    = done_q;
  assign ready   = (state_q == TX_IDLE);
  assign busy    = (state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic       clock;
  logic       reset;
  logic       baud_tick;
  logic       send;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_tx;
  logic       ready;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fails  = 0;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .send        (send),
    .data_in     (data_in),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .data_tx     (data_tx),
    .ready       (ready),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test end");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given tick level; returns 1ns after the edge
  task automatic cyc(input logic tk);
    baud_tick = tk;
    @(posedge clock);
    #1;
    baud_tick = 1'b0;
  endtask

  // Accept one frame, then walk n tick intervals (ticks every third cycle).
  // exp_bits[i] is the hand-computed line level for interval i after T0.
  // disturb >= 0 injects a new send/data/parity during that interval.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] pt,
                           input logic sb, input logic [15:0] exp_bits, input int n,
                           input logic acc_tick, input int disturb);
    data_in     = d;
    parity_type = pt;
    stop_bits   = sb;
    send        = 1'b1;
    cyc(acc_tick);
    send = 1'b0;
    check_eq({tag, " busy after accept"}, {15'd0, busy}, 16'd1);
    check_eq({tag, " ready after accept"}, {15'd0, ready}, 16'd0);
    check_eq({tag, " line after accept"}, {15'd0, data_tx}, 16'd1);
    for (int i = 0; i <= n; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (i == disturb && j == 0) begin
          send        = 1'b1;
          data_in     = 8'hFF;
          parity_type = (pt == ODD) ? EVEN : ODD;
        end
        cyc(1'b0);
        send = 1'b0;
        if (j == 1)
          check_eq($sformatf("%s hold %0d", tag, i), {15'd0, data_tx},
                   {15'd0, (i == 0) ? 1'b1 : exp_bits[i-1]});
      end
      cyc(1'b1);
      if (i < n) begin
        check_eq($sformatf("%s line T%0d+1", tag, i), {15'd0, data_tx}, {15'd0, exp_bits[i]});
        check_eq($sformatf("%s done T%0d+1", tag, i), {15'd0, done}, 16'd0);
      end else begin
        check_eq({tag, " done at end"}, {15'd0, done}, 16'd1);
        check_eq({tag, " busy at end"}, {15'd0, busy}, 16'd0);
        check_eq({tag, " ready at end"}, {15'd0, ready}, 16'd1);
        check_eq({tag, " line at end"}, {15'd0, data_tx}, 16'd1);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    baud_tick   = 1'b0;
    send        = 1'b0;
    data_in     = 8'h00;
    parity_type = NOPARITY00;
    stop_bits   = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    reset = 1'b0;

    check_eq("reset data_tx", {15'd0, data_tx}, 16'd1);
    check_eq("reset ready", {15'd0, ready}, 16'd1);
    check_eq("reset busy", {15'd0, busy}, 16'd0);
    check_eq("reset done", {15'd0, done}, 16'd0);

    // Idle with ticks running: nothing moves
    for (int i = 0; i < 8; i++) begin
      cyc(i[0]);
      check_eq($sformatf("idle line %0d", i), {15'd0, data_tx}, 16'd1);
      check_eq($sformatf("idle state %0d", i), {13'd0, ready, busy, done}, 16'b100);
    end

    // A5 odd, 1 stop: 0,1,0,1,0,0,1,0,1,p=1,s=1
    run_frame("a5_odd", 8'hA5, ODD, 1'b0, 16'h074A, 11, 1'b0, -1);
    // A5 even, 2 stops: parity 0, two stop intervals
    run_frame("a5_even", 8'hA5, EVEN, 1'b1, 16'h0D4A, 12, 1'b0, -1);
    // 00, no parity (00), 1 stop
    run_frame("zero_np", 8'h00, NOPARITY00, 1'b0, 16'h0200, 10, 1'b0, -1);

    // 3C odd, with FF/parity change injected during DATA
    run_frame("3c_odd", 8'h3C, ODD, 1'b0, 16'h0678, 11, 1'b0, 3);
    for (int i = 0; i < 6; i++) begin
      cyc(i[0]);
      check_eq($sformatf("after 3c busy %0d", i), {15'd0, busy}, 16'd0);
      check_eq($sformatf("after 3c line %0d", i), {15'd0, data_tx}, 16'd1);
    end

    // Abort with reset at T5
    data_in     = 8'hA5;
    parity_type = ODD;
    stop_bits   = 1'b0;
    send        = 1'b1;
    cyc(1'b0);
    send = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0);
      cyc(1'b1);
    end
    cyc(1'b0);
    reset = 1'b1;
    cyc(1'b1);
    reset = 1'b0;
    check_eq("abort line", {15'd0, data_tx}, 16'd1);
    check_eq("abort state", {13'd0, ready, busy, done}, 16'b100);
    for (int i = 0; i < 14; i++) begin
      cyc(1'b0);
      cyc(1'b1);
      check_eq($sformatf("abort no done %0d", i), {15'd0, done}, 16'd0);
      check_eq($sformatf("abort idle line %0d", i), {15'd0, data_tx}, 16'd1);
    end
    run_frame("81_odd", 8'h81, ODD, 1'b0, 16'h0702, 11, 1'b0, -1);

    // Tick in the acceptance cycle, then chained send in the done cycle
    cyc(1'b0);
    run_frame("b2b_first", 8'hA5, ODD, 1'b0, 16'h074A, 11, 1'b1, -1);
    run_frame("b2b_second", 8'h00, NOPARITY11, 1'b1, 16'h0600, 11, 1'b0, -1);
    cyc(1'b0);
    check_eq("done single pulse", {15'd0, done}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
